// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, long-op holds, redirect flushes.
// Outputs are combinational from state and inputs; counters saturate.
module hazard_ctrl_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_long_busy,
    input  logic             redirect,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        LD_STALL,
        LONG_STALL
    } state_t;

    localparam logic [3:0] LD_INIT = 4'(LOAD_LAT - 1);

    state_t     state, state_nx;
    logic [3:0] ld_cnt, ld_cnt_nx;
    logic       lu_hit;

    assign lu_hit = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    // LONG_STALL with busy low behaves exactly like RUN, so it needs no branch
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        state_nx     = state;
        ld_cnt_nx    = ld_cnt;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nx     = RUN;
            ld_cnt_nx    = '0;
        end else if (ex_long_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
            state_nx    = LONG_STALL;
            ld_cnt_nx   = '0;
        end else if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nx     = RUN;
            ld_cnt_nx    = '0;
        end else if (state == LD_STALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (ld_cnt <= 4'd1) begin
                state_nx  = RUN;
                ld_cnt_nx = '0;
            end else begin
                ld_cnt_nx = ld_cnt - 4'd1;
            end
        end else if (lu_hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nx  = LD_STALL;
                ld_cnt_nx = LD_INIT;
            end else begin
                state_nx  = RUN;
            end
        end else begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ld_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nx;
            ld_cnt <= ld_cnt_nx;
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (if_id_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: LOAD_LAT=3/CNT_W=4 main instance plus a LOAD_LAT=1 instance.
// Stimulus pushes expected values; a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       ex_mem_read = 1'b0, ex_long_busy = 1'b0, redirect = 1'b0;

    logic        pw3, iw3, fl3, bu3, ho3;
    logic [3:0]  sc3, fc3;
    logic        pw1, iw1, fl1, bu1, ho1;
    logic [31:0] sc1, fc1;

    // control pattern order: pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold
    localparam logic [4:0] PASS  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] HOLD  = 5'b00001;
    localparam logic [4:0] RSTO  = 5'b00110;

    logic [12:0] q3[$];
    logic [33:0] q1[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) u_l3 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_long_busy(ex_long_busy), .redirect(redirect),
        .pc_write(pw3), .if_id_write(iw3), .if_id_flush(fl3),
        .id_ex_bubble(bu3), .ex_hold(ho3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    hazard_ctrl_unit #(.REG_W(5), .LOAD_LAT(1), .CNT_W(32)) u_l1 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_long_busy(ex_long_busy), .redirect(redirect),
        .pc_write(pw1), .if_id_write(iw1), .if_id_flush(fl1),
        .id_ex_bubble(bu1), .ex_hold(ho1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    always @(negedge clk) begin
        logic [12:0] e3, a3;
        logic [33:0] e1, a1;
        if (q3.size() > 0) begin
            e3 = q3.pop_front();
            a3 = {pw3, iw3, fl3, bu3, ho3, sc3, fc3};
            checks++;
            if (a3 !== e3) begin
                failures++;
                $display("FAIL l3 @%0t ctl/sc/fc got %b/%0d/%0d want %b/%0d/%0d",
                         $time, a3[12:8], a3[7:4], a3[3:0],
                         e3[12:8], e3[7:4], e3[3:0]);
            end
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            a1 = {pw1, bu1, sc1};
            checks++;
            if (a1 !== e1) begin
                failures++;
                $display("FAIL l1 @%0t pw/bu/sc got %b%b/%0d want %b%b/%0d",
                         $time, a1[33], a1[32], a1[31:0],
                         e1[33], e1[32], e1[31:0]);
            end
        end
    end

    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic bz, input logic rdr);
        @(posedge clk);
        #1;
        rst = r;
        id_rs1 = a1;
        id_rs2 = a2;
        id_use_rs1 = u1;
        id_use_rs2 = u2;
        ex_rd = rd;
        ex_mem_read = mr;
        ex_long_busy = bz;
        redirect = rdr;
    endtask

    // idle: no load in EX, optional busy/redirect
    task automatic idle(input logic bz, input logic rdr);
        step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, bz, rdr);
    endtask

    // load to x5 in EX, ID reads rs1=x5
    task automatic hazard(input logic bz, input logic rdr);
        step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, bz, rdr);
    endtask

    task automatic e3(input logic [4:0] ctl, input int sc, input int fc);
        q3.push_back({ctl, 4'(sc), 4'(fc)});
    endtask

    task automatic e1(input logic pw, input logic bu, input int sc);
        q1.push_back({pw, bu, 32'(sc)});
    endtask

    initial begin
        // reset held, then released
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        e3(RSTO, 0, 0); e1(1'b0, 1'b1, 0);
        idle(1'b0, 1'b0);  e3(PASS, 0, 0);  e1(1'b1, 1'b0, 0);
        // load-use: 3 stall cycles on l3, exactly 1 on l1
        hazard(1'b0, 1'b0); e3(STALL, 0, 0); e1(1'b0, 1'b1, 0);
        idle(1'b0, 1'b0);  e3(STALL, 1, 0); e1(1'b1, 1'b0, 1);
        idle(1'b0, 1'b0);  e3(STALL, 2, 0); e1(1'b1, 1'b0, 1);
        idle(1'b0, 1'b0);  e3(PASS, 3, 0);  e1(1'b1, 1'b0, 1);
        // x0 never hazards; unused rs2 never hazards; used rs2 does
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        e3(PASS, 3, 0);
        step(1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        e3(PASS, 3, 0);
        step(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        e3(STALL, 3, 0);
        // redirect in stall cycle 2 aborts it
        idle(1'b0, 1'b1);  e3(FLUSH, 4, 0);
        idle(1'b0, 1'b0);  e3(PASS, 4, 1);
        // plain redirect in RUN
        idle(1'b0, 1'b1);  e3(FLUSH, 4, 1);
        idle(1'b0, 1'b0);  e3(PASS, 4, 2);
        // long op busy 5 cycles, hazard and redirect ignored while busy
        idle(1'b1, 1'b0);   e3(HOLD, 4, 2);
        hazard(1'b1, 1'b0); e3(HOLD, 5, 2);
        idle(1'b1, 1'b1);   e3(HOLD, 6, 2);
        idle(1'b1, 1'b0);   e3(HOLD, 7, 2);
        idle(1'b1, 1'b0);   e3(HOLD, 8, 2);
        idle(1'b0, 1'b0);   e3(PASS, 9, 2);
        // redirect beats load-use
        hazard(1'b0, 1'b1); e3(FLUSH, 9, 2);
        idle(1'b0, 1'b0);   e3(PASS, 9, 3);
        // async reset in the middle of a load stall
        hazard(1'b0, 1'b0); e3(STALL, 9, 3);
        idle(1'b0, 1'b0);   e3(STALL, 10, 3);
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        e3(RSTO, 0, 0);
        idle(1'b0, 1'b0);   e3(PASS, 0, 0);
        idle(1'b0, 1'b0);   e3(PASS, 0, 0);
        // 20 stall cycles saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            idle(1'b1, 1'b0);
            e3(HOLD, (i > 15) ? 15 : i, 0);
        end
        idle(1'b0, 1'b0);   e3(PASS, 15, 0);

        for (int i = 0; i < 10 && (q3.size() > 0 || q1.size() > 0); i++) begin
            @(negedge clk);
            #1;
        end
        if (q3.size() > 0 || q1.size() > 0) begin
            failures++;
            $display("FAIL drain left=%0d want 0", q3.size() + q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
